// File: rtl/seg7_pkg.sv
// Seven-segment glyph patterns (active-low, g..a) and their codes,
// shared by the capture decoder and the BCD-to-segment encoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_E    = 4'hE;

    function automatic logic [6:0] seg7_encode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            CODE_E:  s = SEG_E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational segment-pattern decoder: seg -> {ok, code}.
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       ok_o,
    output logic [3:0] code_o
);

    always_comb begin
        ok_o   = 1'b1;
        code_o = 4'd0;
        case (seg_i)
            SEG_0:   code_o = 4'd0;
            SEG_1:   code_o = 4'd1;
            SEG_2:   code_o = 4'd2;
            SEG_3:   code_o = 4'd3;
            SEG_4:   code_o = 4'd4;
            SEG_5:   code_o = 4'd5;
            SEG_6:   code_o = 4'd6;
            SEG_7:   code_o = 4'd7;
            SEG_8:   code_o = 4'd8;
            SEG_9:   code_o = 4'd9;
            SEG_E:   code_o = CODE_E;
            default: ok_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Recovers digit codes from a multiplexed seven-segment display bus,
// debouncing each dwell and publishing a frame once every position is seen.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter  int STABLE_CYC = 4,
    parameter  int NDIG       = 4,
    localparam int EW         = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NDIG-1:0]   an,
    input  logic [6:0]        seg,
    output logic [4*NDIG-1:0] digits,
    output logic              valid,
    output logic              err,
    output logic [EW-1:0]     err_digit
);

    localparam logic [7:0] CMAX = 8'(STABLE_CYC - 1);
    localparam logic [7:0] CCAP = 8'(STABLE_CYC - 2);

    logic [NDIG-1:0]   prev_an_q;
    logic [6:0]        prev_seg_q;
    logic [7:0]        cnt_q, cnt_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic [4*NDIG-1:0] digits_q;
    logic              valid_q;
    logic              err_q;
    logic [EW-1:0]     err_digit_q;

    logic [NDIG-1:0]   sel;
    logic              legal;
    logic              same;
    logic              capture;
    logic              frame_done;
    logic [EW-1:0]     pos;
    logic              dec_ok;
    logic [3:0]        dec_code;

    seg7_dec u_dec (
        .seg_i  (seg),
        .ok_o   (dec_ok),
        .code_o (dec_code)
    );

    always_comb begin
        sel   = ~an;
        legal = (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);
        same  = (an == prev_an_q) && (seg == prev_seg_q);
        pos   = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an[i]) pos = EW'(i);
        end
    end

    // Counter saturates so a long dwell yields exactly one capture.
    always_comb begin
        cnt_d = 8'd0;
        if (legal && same) cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + 8'd1;
        capture = legal && same && (cnt_q == CCAP);
    end

    always_comb begin
        shadow_d = shadow_q;
        shadow_d[int'(pos)*4 +: 4] = dec_code;
        seen_d     = seen_q | (NDIG'(1) << pos);
        frame_done = capture && dec_ok && (&seen_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_an_q   <= '1;
            prev_seg_q  <= SEG_BLANK;
            cnt_q       <= 8'd0;
            shadow_q    <= '0;
            seen_q      <= '0;
            digits_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= '0;
        end else begin
            prev_an_q  <= an;
            prev_seg_q <= seg;
            cnt_q      <= cnt_d;
            valid_q    <= frame_done;
            err_q      <= capture && !dec_ok;
            if (capture && !dec_ok) err_digit_q <= pos;
            if (capture && dec_ok) begin
                shadow_q <= shadow_d;
                seen_q   <= frame_done ? '0 : seen_d;
            end
            if (frame_done) digits_q <= shadow_d;
        end
    end

    assign digits    = digits_q;
    assign valid     = valid_q;
    assign err       = err_q;
    assign err_digit = err_digit_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: a dwell-level reference model queues
// expected valid/err events which a negedge monitor pops and compares.
module tb_seg7_capture;
    import seg7_pkg::*;

    localparam int SC = 4;
    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic        valid;
    logic        err;
    logic [1:0]  err_digit;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_capture #(.STABLE_CYC(SC), .NDIG(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .an        (an),
        .seg       (seg),
        .digits    (digits),
        .valid     (valid),
        .err       (err),
        .err_digit (err_digit)
    );

    // Independent glyph table; index is the code, entry 10 is the E glyph.
    logic [6:0] pat [11] = '{7'b1000000, 7'b1111001, 7'b0100100,
                             7'b0110000, 7'b0011001, 7'b0010010,
                             7'b0000010, 7'b1111000, 7'b0000000,
                             7'b0010000, 7'b0000110};

    typedef struct {
        bit          is_err;
        logic [15:0] dig;
        logic [1:0]  ed;
        int          at;
    } ev_t;

    ev_t evq[$];

    bit          pv;
    logic [3:0]  pan;
    logic [6:0]  pseg;
    int          run;
    logic [3:0]  sh [4];
    bit          sn [4];
    logic [15:0] mdig;
    logic [1:0]  med;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, got, exp, cyc);
        end
    endtask

    function automatic int lookup(input logic [6:0] s);
        for (int k = 0; k < 11; k++)
            if (pat[k] == s) return (k == 10) ? 14 : k;
        return -1;
    endfunction

    task automatic model_reset();
        pv = 0; run = 0; mdig = '0; med = '0;
        for (int k = 0; k < 4; k++) begin sh[k] = '0; sn[k] = 0; end
    endtask

    task automatic model_step(input logic [3:0] a, input logic [6:0] s);
        int z, p, c;
        bit legal, all;
        ev_t e;
        z = 0; p = 0;
        for (int k = 0; k < 4; k++) if (!a[k]) begin z++; p = k; end
        legal = (z == 1);
        if (legal && pv && a == pan && s == pseg) run++;
        else run = legal ? 1 : 0;
        pv = 1; pan = a; pseg = s;
        if (legal && run == SC) begin
            c = lookup(s);
            e.at = cyc + 1;
            if (c < 0) begin
                med = 2'(p);
                e.is_err = 1; e.dig = mdig; e.ed = med;
                evq.push_back(e);
            end else begin
                sh[p] = 4'(c); sn[p] = 1;
                all = sn[0] && sn[1] && sn[2] && sn[3];
                if (all) begin
                    mdig = {sh[3], sh[2], sh[1], sh[0]};
                    for (int k = 0; k < 4; k++) sn[k] = 0;
                    e.is_err = 0; e.dig = mdig; e.ed = med;
                    evq.push_back(e);
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s);
        @(posedge clk); #1;
        an = a; seg = s;
        model_step(a, s);
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s,
                         input int n);
        repeat (n) step(a, s);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; an = 4'hF; seg = SEG_BLANK;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_err_digit", 32'(err_digit), 32'h0);
        rst = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (!rst && (valid || err)) begin
            if (evq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_event: valid=%0b err=%0b digits=%h at cycle %0d",
                         valid, err, digits, cyc);
            end else begin
                ev_t e;
                e = evq.pop_front();
                chk("ev_valid", 32'(valid), 32'(!e.is_err));
                chk("ev_err", 32'(err), 32'(e.is_err));
                chk("ev_digits", 32'(digits), 32'(e.dig));
                chk("ev_err_digit", 32'(err_digit), 32'(e.ed));
                chk("ev_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    initial begin
        rst = 1'b1; an = 4'hF; seg = SEG_BLANK;
        model_reset();
        do_reset();

        dwell(4'b1110, seg7_encode(4'd1), 4);
        dwell(4'b1101, seg7_encode(4'd2), 4);
        dwell(4'b1011, seg7_encode(4'd3), 4);
        dwell(4'b0111, seg7_encode(4'd4), 4);
        dwell(4'hF, SEG_BLANK, 3);
        chk("roundtrip_digits", 32'(digits), 32'h4321);

        dwell(4'b1110, SEG_0, 3);
        dwell(4'b1101, SEG_2, 1);
        dwell(4'b1110, SEG_0, 4);
        dwell(4'b1101, SEG_6, 4);
        dwell(4'b1011, SEG_7, 4);
        dwell(4'b0111, SEG_8, 4);

        dwell(4'b1101, SEG_BLANK, 4);
        dwell(4'hF, SEG_BLANK, 4);
        chk("err_digit_held", 32'(err_digit), 32'(med));

        dwell(4'b1100, SEG_3, 10);
        dwell(4'b1111, SEG_3, 10);

        dwell(4'b1110, seg7_encode(4'd5), 4);
        dwell(4'b1101, seg7_encode(4'hE), 4);
        dwell(4'b1110, seg7_encode(4'd9), 4);
        dwell(4'b1011, seg7_encode(4'd7), 4);
        dwell(4'b0111, seg7_encode(4'd8), 4);
        dwell(4'hF, SEG_BLANK, 3);
        chk("overwrite_digits", 32'(digits), 32'h87E9);

        dwell(4'b1110, SEG_1, 4);
        dwell(4'b1101, SEG_1, 4);
        dwell(4'b1011, SEG_1, 4);
        dwell(4'b0111, SEG_1, 2);
        do_reset();
        dwell(4'b0111, SEG_2, 4);
        dwell(4'b1110, SEG_3, 4);
        dwell(4'b1101, SEG_3, 4);
        dwell(4'b1011, SEG_3, 4);
        dwell(4'b0111, SEG_3, 4);

        for (int n = 0; n < 200; n++) begin
            logic [3:0] a;
            logic [6:0] s;
            if ($urandom_range(0, 99) < 85)
                a = ~(4'b0001 << $urandom_range(0, 3));
            else
                a = 4'($urandom);
            if ($urandom_range(0, 99) < 80)
                s = pat[$urandom_range(0, 10)];
            else
                s = 7'($urandom);
            dwell(a, s, $urandom_range(1, 6));
        end

        dwell(4'hF, SEG_BLANK, 5);
        chk("queue_drained", 32'(evq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4: consecutive identical samples required before a digit is accepted; legal range 2..255.
REQ-002 Parameter NDIG, default 4: number of multiplexed digit positions.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 an  input  NDIG: digit-select lines, active-low; an[i]=0 means position i is driven.
REQ-006 seg  input  7: segment lines, active-low, bit order g..a (seg[6]=g, seg[0]=a), synchronous to clk.
REQ-007 digits  output  4*NDIG: last complete frame; digits[4i+3:4i] holds the code for position i.
REQ-008 valid  output  1: one-cycle pulse when digits is updated with a complete frame.
REQ-009 err  output  1: one-cycle pulse when an accepted pattern is not in the decode table.
REQ-010 err_digit  output  clog2(NDIG), minimum 1 bit: position of the most recent err; held until the next err.

Function
REQ-011 Decode table (seg -> code): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0000110->E (blank/overflow glyph); any other pattern is invalid.
REQ-012 Sample legal when exactly one bit of an is 0; otherwise the stability counter clears to 0 and nothing is captured.
REQ-013 Stability: registered copies of the previous an and seg; counter increments while the current {an,seg} equals the previous and saturates at STABLE_CYC-1; any change clears it to 0.
REQ-014 Capture occurs on the edge where the counter reaches STABLE_CYC-1 (the STABLE_CYC-th identical legal sample); exactly one capture per dwell; no recapture until {an,seg} changes.
REQ-015 Valid capture: shadow[i] <= code and seen[i] <= 1 on the capture edge.
REQ-016 Invalid capture: shadow and seen are unchanged; err=1 and err_digit=i on the capture edge.
REQ-017 Frame completion: if the seen mask including the current capture is all ones, digits <= shadow including the current code, valid=1, and seen <= 0, all on that same edge; latency from the STABLE_CYC-th identical sample to valid is 1 clock.
REQ-018 Recapture of an already-seen position before frame completion overwrites shadow[i]; the newest value wins.
REQ-019 The same physical digit value may repeat across dwells; a change in an alone restarts the counter.
REQ-020 The decoder never generates output transitions while idle; valid and err are 0 except on capture edges.

Reset
REQ-021 rst=1 forces digits=0, valid=0, err=0, err_digit=0, seen=0, shadow=0, counter=0, and previous-sample registers to an=all ones, seg=1111111.
REQ-022 Reset mid-dwell or mid-frame discards partial captures; after release, the first capture requires STABLE_CYC fresh identical samples.

Structure
REQ-023 Package seg7_pkg holds the 11 segment-pattern constants and their codes, shared with the existing BCD-to-segment encoder.
REQ-024 Sub-module seg7_dec: purely combinational seg[6:0] -> {ok, code[3:0]}, instantiated once.

Verification
REQ-025 Round trip: drive the encoder output for frame 1,2,3,4 on an=1110,1101,1011,0111, each for 4 cycles -> one valid pulse, digits=16'h4321, err never set.
REQ-026 Glitch: hold seg=1000000 on an=1110 for 3 cycles, then change -> no capture and seen stays 0; hold it for 4 cycles -> shadow[0]=0 and seen[0]=1.
REQ-027 Invalid pattern: seg=1111111 stable 4 cycles on an=1101 -> err pulses 1 cycle, err_digit=1, digits unchanged, no valid.
REQ-028 Illegal select: an=1100 or an=1111 with stable seg for 10 cycles -> no capture, no err, no valid.
REQ-029 Overwrite: capture 5 then 9 on position 0 before the other positions complete -> valid frame has digits[3:0]=9; code E on any position decodes to 4'hE.
REQ-030 Reset: assert rst after 3 positions are captured, then release -> all outputs 0, and a complete new frame is required before valid.
